// File: rtl/prog_mem_pkg.sv
// rtl/prog_mem_pkg.sv - shared types, constants and parity helper for prog_mem
//
// Contents:
//   state_t      FSM state encoding (EMPTY, LOAD, RUN)
//   PAR_MAX_W    widest word the parity helper accepts (callers zero-extend)
//   NOP          all-zeros instruction word (slice to DATA_W)
//   even_parity  returns the bit that makes the word plus that bit XOR to 0
package prog_mem_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        LOAD  = 2'd1,
        RUN   = 2'd2
    } state_t;

    localparam int PAR_MAX_W = 64;

    localparam logic [PAR_MAX_W-1:0] NOP = '0;

    // Zero-extension does not change the XOR, so one fixed-width helper
    // serves every DATA_W up to PAR_MAX_W.
    function automatic logic even_parity(input logic [PAR_MAX_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/prog_mem_array.sv
// rtl/prog_mem_array.sv - program storage, one write port and one synchronous read port
//
// Parameters: WIDTH (stored word width), ADDR_W (DEPTH = 2**ADDR_W)
// Ports:
//   clk    rising-edge clock
//   we     write enable
//   waddr  write address
//   wdata  write word
//   raddr  read address, sampled every cycle
//   rdata  read word, registered (one cycle after raddr)
// Contents are never reset. A same-address write and read return the old
// word (read-first), because both use non-blocking updates on the same edge.
module prog_mem_array #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/prog_mem.sv
// rtl/prog_mem.sv - loadable program memory with EMPTY/LOAD/RUN control FSM
//
// Optional feature: define PROG_MEM_PARITY_EN to store an even-parity bit per
// word and flag read parity errors on par_err; otherwise par_err is tied to 0.
//
// Parameters: DATA_W (instruction width), ADDR_W (DEPTH = 2**ADDR_W)
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   fetch_req, fetch_addr      read request and address
//   fetch_valid, fetch_data    read response, exactly one cycle later
//   load_start                 pulse that (re)starts a program load
//   load_valid, load_data,
//   load_last, load_ready      load word stream with valid/ready handshake
//   busy                       high while loading
//   par_err                    read parity error, aligned with fetch_valid
import prog_mem_pkg::*;

module prog_mem #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_valid,
    output logic [DATA_W-1:0] fetch_data,
    input  logic              load_start,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    output logic              load_ready,
    output logic              busy,
    output logic              par_err
);

`ifdef PROG_MEM_PARITY_EN
    localparam int MEM_W = DATA_W + 1;
`else
    localparam int MEM_W = DATA_W;
`endif

    state_t            state;
    logic [ADDR_W-1:0] wptr;
    logic              rd_run;     // the request answered now was issued in RUN
    logic              accept;
    logic              last_word;
    logic [MEM_W-1:0]  wr_word;
    logic [MEM_W-1:0]  rd_word;

    // load_ready is only ever high in LOAD, so it alone qualifies the handshake.
    assign accept    = load_valid && load_ready;
    assign last_word = load_last || (wptr == {ADDR_W{1'b1}});

`ifdef PROG_MEM_PARITY_EN
    assign wr_word = {even_parity(PAR_MAX_W'(load_data)), load_data};
`else
    assign wr_word = load_data;
`endif

    prog_mem_array #(
        .WIDTH  (MEM_W),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk   (clk),
        .we    (accept),
        .waddr (wptr),
        .wdata (wr_word),
        .raddr (fetch_addr),
        .rdata (rd_word)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= EMPTY;
            wptr        <= '0;
            load_ready  <= 1'b0;
            busy        <= 1'b0;
            fetch_valid <= 1'b0;
            rd_run      <= 1'b0;
        end else begin
            fetch_valid <= fetch_req;
            // State is sampled in the request cycle, so a fetch alongside the
            // final load word still sees LOAD and returns NOP.
            rd_run      <= fetch_req && (state == RUN);
            case (state)
                EMPTY, RUN: begin
                    if (load_start) begin
                        state      <= LOAD;
                        wptr       <= '0;
                        load_ready <= 1'b1;
                        busy       <= 1'b1;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        if (last_word) begin
                            state      <= RUN;
                            load_ready <= 1'b0;
                            busy       <= 1'b0;
                        end else begin
                            wptr <= wptr + 1'b1;
                        end
                    end
                end
                default: begin
                    state      <= EMPTY;
                    load_ready <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

    // rd_run implies fetch_valid, so this also holds fetch_data at 0 when idle.
    assign fetch_data = rd_run ? rd_word[DATA_W-1:0] : NOP[DATA_W-1:0];

`ifdef PROG_MEM_PARITY_EN
    assign par_err = rd_run && (^rd_word);
`else
    assign par_err = 1'b0;
`endif

endmodule

// File: tb/tb_prog_mem.sv
// tb/tb_prog_mem.sv - self-checking bench for prog_mem (vector table plus directed sequences)
module tb_prog_mem;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_req;
    logic [7:0]  fetch_addr;
    logic        fetch_valid;
    logic [15:0] fetch_data;
    logic        load_start;
    logic        load_valid;
    logic [15:0] load_data;
    logic        load_last;
    logic        load_ready;
    logic        busy;
    logic        par_err;

    int checks = 0;
    int errors = 0;

    prog_mem #(.DATA_W(16), .ADDR_W(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .fetch_req   (fetch_req),
        .fetch_addr  (fetch_addr),
        .fetch_valid (fetch_valid),
        .fetch_data  (fetch_data),
        .load_start  (load_start),
        .load_valid  (load_valid),
        .load_data   (load_data),
        .load_last   (load_last),
        .load_ready  (load_ready),
        .busy        (busy),
        .par_err     (par_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic        freq;
        logic [7:0]  faddr;
        logic        lstart;
        logic        lvalid;
        logic [15:0] ldata;
        logic        llast;
        logic        e_valid;
        logic [15:0] e_data;
        logic        e_busy;
        logic        e_ready;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic r, input logic fq, input logic [7:0] fa,
                                input logic ls, input logic lv, input logic [15:0] ld,
                                input logic ll, input logic ev, input logic [15:0] ed,
                                input logic eb, input logic er);
        vec_t v;
        v.rst_n = r;  v.freq = fq;  v.faddr = fa;  v.lstart = ls;
        v.lvalid = lv; v.ldata = ld; v.llast = ll;
        v.e_valid = ev; v.e_data = ed; v.e_busy = eb; v.e_ready = er;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic fq, input logic [7:0] fa,
                         input logic ls, input logic lv, input logic [15:0] ld, input logic ll);
        rst_n = r; fetch_req = fq; fetch_addr = fa;
        load_start = ls; load_valid = lv; load_data = ld; load_last = ll;
    endtask

    // Outputs are sampled 1 ns after the edge that consumed the inputs.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] word_of(input int i);
        logic [7:0] b;
        b = i[7:0];
        return {b, ~b};
    endfunction

    initial begin
        drive(0, 0, 8'h00, 0, 0, 16'h0000, 0);

        //   rst fq  addr  ls lv data      ll | ev data      busy ready
        add(0, 0, 8'h00, 0, 0, 16'h0000, 0,  0, 16'h0000, 0, 0);
        add(0, 1, 8'h05, 0, 0, 16'h0000, 0,  0, 16'h0000, 0, 0);
        add(1, 1, 8'h05, 0, 0, 16'h0000, 0,  1, 16'h0000, 0, 0);
        add(1, 0, 8'h00, 0, 0, 16'h0000, 0,  0, 16'h0000, 0, 0);
        add(1, 0, 8'h00, 1, 0, 16'h0000, 0,  0, 16'h0000, 1, 1);
        add(1, 1, 8'h00, 0, 1, 16'hC00F, 0,  1, 16'h0000, 1, 1);
        add(1, 1, 8'h00, 1, 1, 16'hD8F0, 0,  1, 16'h0000, 1, 1);
        add(1, 1, 8'h01, 0, 1, 16'hE8FF, 0,  1, 16'h0000, 1, 1);
        add(1, 1, 8'h00, 0, 1, 16'h472D, 1,  1, 16'h0000, 0, 0);
        add(1, 1, 8'h00, 0, 1, 16'hFFFF, 0,  1, 16'hC00F, 0, 0);
        add(1, 1, 8'h01, 0, 0, 16'h0000, 0,  1, 16'hD8F0, 0, 0);
        add(1, 1, 8'h02, 0, 0, 16'h0000, 0,  1, 16'hE8FF, 0, 0);
        add(1, 1, 8'h03, 0, 0, 16'h0000, 0,  1, 16'h472D, 0, 0);
        add(1, 0, 8'h00, 0, 0, 16'h0000, 0,  0, 16'h0000, 0, 0);
        // reload with load_valid toggling and fetches held high
        add(1, 1, 8'h00, 1, 0, 16'h0000, 0,  1, 16'hC00F, 1, 1);
        add(1, 1, 8'h00, 0, 1, 16'h1111, 0,  1, 16'h0000, 1, 1);
        add(1, 1, 8'h01, 0, 0, 16'h2222, 0,  1, 16'h0000, 1, 1);
        add(1, 1, 8'h02, 0, 1, 16'h3333, 0,  1, 16'h0000, 1, 1);
        add(1, 1, 8'h03, 0, 0, 16'h4444, 0,  1, 16'h0000, 1, 1);
        add(1, 1, 8'h00, 0, 1, 16'h5555, 1,  1, 16'h0000, 0, 0);
        add(1, 1, 8'h00, 0, 0, 16'h0000, 0,  1, 16'h1111, 0, 0);
        add(1, 1, 8'h01, 0, 0, 16'h0000, 0,  1, 16'h3333, 0, 0);
        add(1, 1, 8'h02, 0, 0, 16'h0000, 0,  1, 16'h5555, 0, 0);
        add(1, 1, 8'h03, 0, 0, 16'h0000, 0,  1, 16'h472D, 0, 0);
        // reset after the second word of a load
        add(1, 0, 8'h00, 1, 0, 16'h0000, 0,  0, 16'h0000, 1, 1);
        add(1, 0, 8'h00, 0, 1, 16'hAAAA, 0,  0, 16'h0000, 1, 1);
        add(1, 0, 8'h00, 0, 1, 16'hBBBB, 0,  0, 16'h0000, 1, 1);
        add(0, 0, 8'h00, 0, 0, 16'h0000, 0,  0, 16'h0000, 0, 0);
        add(1, 1, 8'h00, 0, 0, 16'h0000, 0,  1, 16'h0000, 0, 0);
        add(1, 1, 8'h00, 0, 1, 16'hCCCC, 0,  1, 16'h0000, 0, 0);
        add(1, 0, 8'h00, 0, 0, 16'h0000, 0,  0, 16'h0000, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst_n, vecs[i].freq, vecs[i].faddr, vecs[i].lstart,
                  vecs[i].lvalid, vecs[i].ldata, vecs[i].llast);
            step();
            check($sformatf("row%0d fetch_valid", i), 32'(fetch_valid), 32'(vecs[i].e_valid));
            check($sformatf("row%0d fetch_data", i),  32'(fetch_data),  32'(vecs[i].e_data));
            check($sformatf("row%0d busy", i),        32'(busy),        32'(vecs[i].e_busy));
            check($sformatf("row%0d load_ready", i),  32'(load_ready),  32'(vecs[i].e_ready));
            check($sformatf("row%0d par_err", i),     32'(par_err),     32'h0);
        end

        // Full-depth load without load_last: RUN after word 255, no wrap.
        drive(1, 0, 8'h00, 1, 0, 16'h0000, 0);
        step();
        check("full load_ready at start", 32'(load_ready), 32'h1);
        for (int i = 0; i < 256; i++) begin
            drive(1, 0, 8'h00, 0, 1, word_of(i), 0);
            step();
            if (i == 254) check("full busy after word 254", 32'(busy), 32'h1);
        end
        check("full busy after word 255", 32'(busy), 32'h0);
        check("full load_ready after word 255", 32'(load_ready), 32'h0);
        drive(1, 0, 8'h00, 0, 1, 16'hDEAD, 0);
        step();
        drive(1, 1, 8'hFF, 0, 0, 16'h0000, 0);
        step();
        check("full fetch ff valid", 32'(fetch_valid), 32'h1);
        check("full fetch ff data", 32'(fetch_data), 32'(16'hFF00));
        drive(1, 1, 8'h00, 0, 0, 16'h0000, 0);
        step();
        check("full fetch 00 data", 32'(fetch_data), 32'(16'h00FF));
        drive(1, 1, 8'h80, 0, 0, 16'h0000, 0);
        step();
        check("full fetch 80 data", 32'(fetch_data), 32'(16'h807F));
        drive(1, 0, 8'h00, 0, 0, 16'h0000, 0);
        step();
        check("full idle data", 32'(fetch_data), 32'h0);

`ifdef PROG_MEM_PARITY_EN
        dut.u_array.mem[3][0] = ~dut.u_array.mem[3][0];
        drive(1, 1, 8'h03, 0, 0, 16'h0000, 0);
        step();
        check("parity bad valid", 32'(fetch_valid), 32'h1);
        check("parity bad par_err", 32'(par_err), 32'h1);
        check("parity bad data", 32'(fetch_data), 32'(16'h03FD));
        drive(1, 1, 8'h02, 0, 0, 16'h0000, 0);
        step();
        check("parity good par_err", 32'(par_err), 32'h0);
        check("parity good data", 32'(fetch_data), 32'(16'h02FD));
        drive(1, 0, 8'h00, 0, 0, 16'h0000, 0);
        step();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
